// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Owns the architectural HI/LO registers; one iteration per clock, WIDTH iterations per op.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             RESET_in,
  input  logic             MultOp,
  input  logic             DivOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             DivZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mcand_ext, booth_sum, rem_shift;
  logic [WIDTH+1:0] trial;

  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      p_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  // P carries one guard bit so that subtracting a most-negative multiplicand cannot overflow.
  always_comb begin
    a_mag     = A[WIDTH-1] ? -A : A;
    b_mag     = B[WIDTH-1] ? -B : B;
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = p_q + mcand_ext;
      2'b10:   booth_sum = p_q - mcand_ext;
      default: booth_sum = p_q;
    endcase
    rem_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, mcand_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MultOp) begin
          is_div_d = 1'b0;
          mcand_d  = A;
          p_d      = '0;
          q_d      = B;
          qm1_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_ITER;
        end else if (DivOp) begin
          if (B == '0) begin
            dz_d = 1'b1;
          end else begin
            is_div_d  = 1'b1;
            mcand_d   = b_mag;
            p_d       = '0;
            q_d       = a_mag;
            qm1_d     = 1'b0;
            neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem_d = A[WIDTH-1];
            cnt_d     = '0;
            state_d   = S_ITER;
          end
        end
      end

      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          // Dividend bits leave Q at the top while quotient bits enter at the bottom.
          if (!trial[WIDTH+1]) begin
            p_d = trial[WIDTH:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            p_d = rem_shift;
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          p_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -q_q : q_q;
          hi_d = neg_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        end else begin
          hi_d = p_q[WIDTH-1:0];
          lo_d = q_q;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected results computed with
// plain 64-bit arithmetic; a negedge monitor checks pulse timing, busy and HI/LO.
module tb_mult_div_unit;

  logic        clock;
  logic        RESET_in;
  logic        MultOp;
  logic        DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        DivZero;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .RESET_in(RESET_in),
    .MultOp  (MultOp),
    .DivOp   (DivOp),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .busy    (busy),
    .done    (done),
    .DivZero (DivZero)
  );

  typedef struct {
    bit          is_dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one step per negedge, decoupled from the driver.
  task automatic mon_step();
    exp_t f;
    bit   have;
    bit   exp_busy;
    have     = (sb.size() > 0);
    exp_busy = 1'b0;
    if (have) begin
      f        = sb[0];
      exp_busy = !f.is_dz && (cyc >= f.due - 33) && (cyc < f.due);
    end
    chk("busy", {63'd0, busy}, {63'd0, exp_busy});
    if (have && cyc == f.due) begin
      void'(sb.pop_front());
      if (f.is_dz) begin
        chk("dz_pulse", {62'd0, DivZero, done}, 64'd2);
        chk("dz_hilo_held", {HI, LO}, {f.hi, f.lo});
      end else begin
        chk("done_pulse", {62'd0, DivZero, done}, 64'd1);
        chk("result_hilo", {HI, LO}, {f.hi, f.lo});
      end
    end else begin
      chk("no_spurious_pulse", {62'd0, DivZero, done}, 64'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!RESET_in) mon_step();
    end
  end

  // Called at a negedge; leaves at the negedge right after the start edge.
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv, r;
    sa      = longint'($signed(a));
    sbv     = longint'($signed(b));
    e.is_dz = 1'b0;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.due   = cyc + 34;
    if (m) begin
      r    = sa * sbv;
      e.hi = r[63:32];
      e.lo = r[31:0];
    end else if (b == 32'd0) begin
      e.is_dz = 1'b1;
      e.due   = cyc + 1;
    end else begin
      r    = sa / sbv;
      e.lo = r[31:0];
      r    = sa % sbv;
      e.hi = r[31:0];
    end
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
    MultOp = m;
    DivOp  = d;
    A      = a;
    B      = b;
    @(negedge clock);
    MultOp = 1'b0;
    DivOp  = 1'b0;
    A      = $urandom;
    B      = $urandom;
  endtask

  task automatic finish_op();
    repeat (33) @(negedge clock);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          op;
    logic [31:0] ra, rb;
    RESET_in = 1'b1;
    MultOp   = 1'b0;
    DivOp    = 1'b0;
    A        = '0;
    B        = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {HI, LO}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, DivZero}, 64'd0);
    RESET_in = 1'b0;
    @(negedge clock);

    issue(1'b1, 1'b0, 32'd7, -32'sd3);
    finish_op();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    finish_op();
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op();
    issue(1'b0, 1'b1, -32'sd7, 32'd2);
    finish_op();
    issue(1'b0, 1'b1, 32'd7, -32'sd2);
    finish_op();
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    repeat (3) @(negedge clock);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op();

    // Multiply request mid-divide must be dropped.
    issue(1'b0, 1'b1, 32'd1000003, -32'sd17);
    repeat (9) @(negedge clock);
    MultOp = 1'b1;
    A      = 32'd3;
    B      = 32'd4;
    @(negedge clock);
    MultOp = 1'b0;
    repeat (23) @(negedge clock);
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    finish_op();

    // Asynchronous reset part-way through the iterations.
    issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (15) @(posedge clock);
    #2;
    RESET_in = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midop_reset_hilo", {HI, LO}, 64'd0);
    chk("midop_reset_flags", {61'd0, busy, done, DivZero}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    RESET_in = 1'b0;
    issue(1'b1, 1'b0, -32'sd12345, 32'd678);
    finish_op();

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      ra = rand_operand();
      rb = rand_operand();
      if (op == 3) rb = 32'd0;
      case (op)
        0:       issue(1'b1, 1'b0, ra, rb);
        2:       issue(1'b1, 1'b1, ra, rb);
        default: issue(1'b0, 1'b1, ra, rb);
      endcase
      if (op == 0 || op == 2 || rb != 32'd0) finish_op();
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
